sine_pwm_dac: RTL and testbench
===============================

SINE_PWM_DAC -- requirements
Module: sine_pwm_dac

Interface
REQ-001 Parameter PERIOD, default 2000: PWM frame length in clk cycles, and the full-scale sample value (sine LUT range 0..2000).
REQ-002 Parameter DW, default 16: sample width.
REQ-003 clk  input  1  single clock; all state changes on its rising edge.
REQ-004 rst  input  1  synchronous reset, active-high.
REQ-005 en  input  1  run enable; low = output idle.
REQ-006 sample_in  input  DW  unsigned duty sample from the sine LUT (o) or any source.
REQ-007 sample_valid  input  1  sample_in valid this cycle.
REQ-008 sample_ready  output  1  block can accept sample_in this cycle.
REQ-009 pwm_out  output  1  PWM bit driving the external RC filter / DAC.
REQ-010 frame_start  output  1  high during the first cycle of each enabled frame.
REQ-011 underrun  output  1  one-cycle pulse: frame started with no new sample.
REQ-012 underrun_cnt  output  8  saturating count of underruns.

Function
REQ-013 Frame counter cnt SHALL run 0..PERIOD-1 while en=1, +1 per cycle, and wrap from PERIOD-1 to 0.
REQ-014 While en=0, cnt SHALL be held at PERIOD-1; pwm_out and frame_start SHALL be 0.
REQ-015 A load event SHALL occur on every cycle with en=1 and cnt==PERIOD-1, including the first enabled cycle after idle.
REQ-016 The block SHALL hold a one-entry pending buffer; a transfer occurs when sample_valid && sample_ready.
REQ-017 sample_ready SHALL be 1 when the pending buffer is empty or a load event occurs in the same cycle.
REQ-018 Transferred samples SHALL be clamped to PERIOD: any value > PERIOD is stored as PERIOD.
REQ-019 On a load event with the buffer full, duty SHALL take the pending value at the next edge and the buffer SHALL empty, unless a transfer occurs in the same cycle, in which case the buffer refills with the new sample.
REQ-020 On a load event with the buffer empty, duty SHALL hold its previous value; underrun SHALL be 1 during the following cycle (cnt==0); underrun_cnt SHALL increment, saturating at 255.
REQ-021 The buffer SHALL accept transfers while en=0; duty SHALL change only on load events.
REQ-022 pwm_out SHALL be en && (cnt < duty), from registered cnt/duty only: duty=0 gives constant 0; duty=PERIOD gives constant 1 for the frame.
REQ-023 frame_start SHALL be en && (cnt==0).
REQ-024 A new sample SHALL reach pwm_out no earlier than the next frame boundary; duty SHALL never change mid-frame.
REQ-025 The counter and comparison width SHALL be sized to hold PERIOD; no truncation of duty.

Reset
REQ-026 On rst=1 at a clock edge: cnt=PERIOD-1, duty=0, buffer empty, underrun_cnt=0.
REQ-027 Reset SHALL dominate en and sample_valid; a sample presented in the reset cycle SHALL be discarded.
REQ-028 Outputs after reset: pwm_out=0, frame_start=0, underrun=0, sample_ready=1.
REQ-029 Reset asserted mid-frame SHALL abort the frame; with en=1 afterwards, the next cycle is a load event (REQ-015).

Verification (PERIOD=10 override unless stated)
REQ-030 Reset, push 4, en=1 -> frame_start at cnt=0; pwm_out high 4 cycles then low 6, repeating.
REQ-031 Push 0 then 10, then 25 -> frames all-low, all-high, all-high (25 clamped to 10).
REQ-032 Buffer full, sample_valid held -> sample_ready=0 until the load cycle; ready=1 on the load cycle; new sample captured; no sample lost or duplicated.
REQ-033 No samples after the first -> underrun pulses at each cnt==0; duty repeats; underrun_cnt saturates at 255 after 300 frames.
REQ-034 en dropped mid-frame at cnt=5 -> pwm_out=0 next cycle and cnt=PERIOD-1; re-enable -> fresh frame from cnt=0 with the pending sample.
REQ-035 PERIOD=2000, fed from the 64-entry sine LUT indexed 0..63 cyclically -> per-frame high time equals the LUT value (1000, 1098, ... 902); no underruns.

Source files
------------

// File: rtl/sine_pwm_dac.sv
// rtl/sine_pwm_dac.sv - frame-based PWM DAC with a one-entry sample buffer
// Duty changes only at frame boundaries; a missing sample repeats the last duty.
module sine_pwm_dac #(
  parameter int PERIOD = 2000,
  parameter int DW     = 16
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic          i_en,
  input  logic [DW-1:0] i_sample_in,
  input  logic          i_sample_valid,
  output logic          o_sample_ready,
  output logic          o_pwm_out,
  output logic          o_frame_start,
  output logic          o_underrun,
  output logic [7:0]    o_underrun_cnt
);
  localparam int            CW        = $clog2(PERIOD + 1);
  localparam logic [CW-1:0] C_LAST    = CW'(PERIOD - 1);
  localparam logic [CW-1:0] C_FULL    = CW'(PERIOD);
  localparam logic [DW-1:0] C_FULL_DW = DW'(PERIOD);

  logic [CW-1:0] r_cnt;
  logic [CW-1:0] r_duty;
  logic [CW-1:0] r_buf;
  logic          r_buf_full;
  logic          r_underrun;
  logic [7:0]    r_underrun_cnt;

  logic          w_load;
  logic          w_xfer;
  logic [CW-1:0] w_clamped;

  // Idle holds cnt at the last slot, so the first enabled cycle is already a load.
  assign w_load         = i_en && (r_cnt == C_LAST);
  assign o_sample_ready = !r_buf_full || w_load;
  assign w_xfer         = i_sample_valid && o_sample_ready;
  assign w_clamped      = (i_sample_in > C_FULL_DW) ? C_FULL : i_sample_in[CW-1:0];

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_cnt          <= C_LAST;
      r_duty         <= '0;
      r_buf          <= '0;
      r_buf_full     <= 1'b0;
      r_underrun     <= 1'b0;
      r_underrun_cnt <= '0;
    end else begin
      if (!i_en) begin
        r_cnt <= C_LAST;
      end else if (r_cnt == C_LAST) begin
        r_cnt <= '0;
      end else begin
        r_cnt <= r_cnt + CW'(1);
      end

      r_underrun <= w_load && !r_buf_full;

      if (w_load) begin
        if (r_buf_full) begin
          r_duty <= r_buf;
        end else if (r_underrun_cnt != 8'hFF) begin
          r_underrun_cnt <= r_underrun_cnt + 8'd1;
        end
      end

      // A transfer on a load cycle refills the slot the load just drained.
      if (w_xfer) begin
        r_buf      <= w_clamped;
        r_buf_full <= 1'b1;
      end else if (w_load) begin
        r_buf_full <= 1'b0;
      end
    end
  end

  assign o_pwm_out      = i_en && (r_cnt < r_duty);
  assign o_frame_start  = i_en && (r_cnt == '0);
  assign o_underrun     = r_underrun;
  assign o_underrun_cnt = r_underrun_cnt;

endmodule

// File: tb/tb_sine_pwm_dac.sv
// tb/tb_sine_pwm_dac.sv - self-checking bench for sine_pwm_dac
// Short-frame instance for directed/random checks, default-frame instance for the sine sweep.
module tb_sine_pwm_dac;
  localparam int P  = 10;
  localparam int P2 = 2000;
  localparam int DW = 16;
  localparam int N2 = 10;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst, en, sv;
  logic [DW-1:0] smp;
  logic          rdy, pwm, fs, und;
  logic [7:0]    ucnt;

  logic          rst2, en2, sv2;
  logic [DW-1:0] smp2;
  logic          rdy2, pwm2, fs2, und2;
  logic [7:0]    ucnt2;

  sine_pwm_dac #(.PERIOD(P), .DW(DW)) u_dut (
    .i_clk(clk), .i_rst(rst), .i_en(en), .i_sample_in(smp), .i_sample_valid(sv),
    .o_sample_ready(rdy), .o_pwm_out(pwm), .o_frame_start(fs),
    .o_underrun(und), .o_underrun_cnt(ucnt)
  );

  sine_pwm_dac #(.DW(DW)) u_dut2 (
    .i_clk(clk), .i_rst(rst2), .i_en(en2), .i_sample_in(smp2), .i_sample_valid(sv2),
    .o_sample_ready(rdy2), .o_pwm_out(pwm2), .o_frame_start(fs2),
    .o_underrun(und2), .o_underrun_cnt(ucnt2)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  task automatic timeout(input string name);
    n_checks++;
    n_errors++;
    $display("FAIL %s timed out", name);
  endtask

  // High-time per completed frame, recorded at each frame start.
  int hi_cnt = 0, hi_on = 0;
  int hi_q[$];
  always @(negedge clk) begin
    if (fs) begin
      if (hi_on != 0) hi_q.push_back(hi_cnt);
      hi_cnt = int'(pwm);
      hi_on  = 1;
    end else if (en) begin
      hi_cnt += int'(pwm);
    end
  end

  int hi2_cnt = 0, hi2_on = 0, und2_seen = 0;
  int hi2_q[$];
  always @(negedge clk) begin
    if (und2) und2_seen++;
    if (fs2) begin
      if (hi2_on != 0) hi2_q.push_back(hi2_cnt);
      hi2_cnt = int'(pwm2);
      hi2_on  = 1;
    end else if (en2) begin
      hi2_cnt += int'(pwm2);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_hi();
    hi_q.delete();
    hi_on = 0;
  endtask

  task automatic do_reset();
    rst = 1'b1; en = 1'b0; sv = 1'b0;
    step();
    rst = 1'b0;
  endtask

  task automatic push(input int s, input string name);
    bit ok;
    ok = 0;
    sv = 1'b1; smp = DW'(s);
    for (int k = 0; k < 4 * P && !ok; k++) begin
      @(negedge clk);
      ok = rdy;
      step();
    end
    sv = 1'b0;
    if (!ok) timeout(name);
  endtask

  task automatic wait_fs(input int n, input string name);
    int seen;
    seen = 0;
    for (int k = 0; k < n * P + 4 * P && seen < n; k++) begin
      @(negedge clk);
      if (fs) seen++;
    end
    if (seen < n) timeout(name);
    #1;
  endtask

  typedef struct {
    bit rst, en, sv;
    int s;
    bit chk;
    bit rdy, pwm, fs, und;
    int ucnt;
  } vec_t;
  vec_t tbl[$];

  task automatic add(input bit r, input bit e, input bit v, input int s, input bit c,
                     input bit rd, input bit pw, input bit f, input bit u, input int uc);
    vec_t t;
    t.rst = r; t.en = e; t.sv = v; t.s = s; t.chk = c;
    t.rdy = rd; t.pwm = pw; t.fs = f; t.und = u; t.ucnt = uc;
    tbl.push_back(t);
  endtask

  // Behavioural reference: frame position, current duty, pending-sample queue.
  int m_pos, m_duty, m_ucnt;
  bit m_und;
  int m_pend[$];

  task automatic model_reset();
    m_pos = P - 1; m_duty = 0; m_ucnt = 0; m_und = 0;
    m_pend.delete();
  endtask

  int lut[64];
  bit r_r, r_v, r_e, m_load, m_rdy, m_pwm, m_fs, m_xfer;
  int r_s, idx;

  initial begin
    for (int i = 0; i < 64; i++)
      lut[i] = int'(1000.0 + 1000.0 * $sin(2.0 * 3.141592653589793 * i / 64.0));

    rst = 1'b1; en = 1'b0; sv = 1'b0; smp = '0;
    rst2 = 1'b1; en2 = 1'b0; sv2 = 1'b0; smp2 = '0;
    step();

    // Reset discards sample 7, idle push of 4, then two duty-4 frames.
    add(1, 1, 1, 7, 0, 0, 0, 0, 0, 0);
    add(0, 0, 0, 0, 1, 1, 0, 0, 0, 0);
    add(0, 0, 1, 4, 1, 1, 0, 0, 0, 0);
    add(0, 1, 0, 0, 1, 1, 0, 0, 0, 0);
    for (int f = 0; f < 3; f++)
      for (int j = 0; j < P; j++)
        if (f < 2 || j == 0)
          add(0, 1, 0, 0, 1, 1, j < 4, j == 0, (j == 0) && (f > 0), f);

    for (int i = 0; i < tbl.size(); i++) begin
      rst = tbl[i].rst; en = tbl[i].en; sv = tbl[i].sv; smp = DW'(tbl[i].s);
      @(negedge clk);
      if (tbl[i].chk) begin
        chk($sformatf("vec%0d_ready", i), rdy, tbl[i].rdy);
        chk($sformatf("vec%0d_pwm", i), pwm, tbl[i].pwm);
        chk($sformatf("vec%0d_frame_start", i), fs, tbl[i].fs);
        chk($sformatf("vec%0d_underrun", i), und, tbl[i].und);
        chk($sformatf("vec%0d_underrun_cnt", i), ucnt, tbl[i].ucnt);
      end
      step();
    end

    // Clamping: samples 0, 10, 25 give all-low, all-high, all-high frames.
    do_reset();
    push(0, "clamp_push0");
    en = 1'b1;
    clear_hi();
    push(10, "clamp_push10");
    push(25, "clamp_push25");
    wait_fs(3, "clamp_frames");
    chk("clamp_nframes", hi_q.size(), 3);
    if (hi_q.size() >= 3) begin
      chk("clamp_frame0_hi", hi_q[0], 0);
      chk("clamp_frame1_hi", hi_q[1], P);
      chk("clamp_frame2_hi", hi_q[2], P);
    end
    step();

    // Back-pressure with a full buffer and valid held.
    do_reset();
    push(3, "bp_push3");
    sv = 1'b1; smp = DW'(7);
    @(negedge clk); chk("bp_ready_full_a", rdy, 0); step();
    @(negedge clk); chk("bp_ready_full_b", rdy, 0); step();
    en = 1'b1;
    clear_hi();
    @(negedge clk); chk("bp_ready_on_load", rdy, 1); step();
    sv = 1'b0;
    @(negedge clk);
    chk("bp_ready_after_load", rdy, 0);
    chk("bp_frame_start", fs, 1);
    step();
    wait_fs(1, "bp_fs2");
    chk("bp_no_underrun", und, 0);
    step();
    wait_fs(1, "bp_fs3");
    chk("bp_underrun", und, 1);
    chk("bp_underrun_cnt", ucnt, 1);
    chk("bp_nframes", hi_q.size(), 2);
    if (hi_q.size() >= 2) begin
      chk("bp_frame0_hi", hi_q[0], 3);
      chk("bp_frame1_hi", hi_q[1], 7);
    end
    step();

    // Underrun counter saturation with a single sample.
    do_reset();
    push(5, "sat_push5");
    en = 1'b1;
    clear_hi();
    wait_fs(100, "sat_fs100");
    chk("sat_cnt_100", ucnt, 99);
    step();
    wait_fs(155, "sat_fs255");
    chk("sat_cnt_255", ucnt, 254);
    step();
    wait_fs(1, "sat_fs256");
    chk("sat_cnt_256", ucnt, 255);
    step();
    wait_fs(44, "sat_fs300");
    chk("sat_cnt_300", ucnt, 255);
    chk("sat_underrun_pulse", und, 1);
    chk("sat_nframes", hi_q.size(), 299);
    if (hi_q.size() > 0) chk("sat_duty_repeat", hi_q[hi_q.size() - 1], 5);
    step();

    // Enable dropped mid-frame, then re-enabled with a pending sample.
    do_reset();
    push(6, "en_push6");
    en = 1'b1;
    push(2, "en_push2");
    wait_fs(1, "en_fs");
    for (int k = 0; k < 4; k++) step();
    @(negedge clk); chk("en_pwm_cnt4", pwm, 1); step();
    en = 1'b0;
    @(negedge clk); chk("en_pwm_drop", pwm, 0); step();
    @(negedge clk);
    chk("en_idle_pwm", pwm, 0);
    chk("en_idle_fs", fs, 0);
    chk("en_idle_ready", rdy, 0);
    step();
    en = 1'b1;
    clear_hi();
    @(negedge clk); chk("en_reload_ready", rdy, 1); chk("en_reload_fs", fs, 0); step();
    @(negedge clk); chk("en_fresh_fs", fs, 1); chk("en_fresh_pwm", pwm, 1); step();
    wait_fs(1, "en_fs_next");
    chk("en_fresh_nframes", hi_q.size(), 1);
    if (hi_q.size() >= 1) chk("en_fresh_hi", hi_q[0], 2);
    step();

    // Randomized stimulus against the reference model.
    do_reset();
    model_reset();
    r_e = 1;
    for (int c = 0; c < 3000; c++) begin
      r_r = ($urandom_range(0, 199) == 0);
      if ($urandom_range(0, 24) == 0) r_e = !r_e;
      r_v = $urandom_range(0, 1) != 0;
      r_s = $urandom_range(0, 3 * P / 2);
      rst = r_r; en = r_e; sv = r_v; smp = DW'(r_s);
      m_load = r_e && (m_pos == P - 1);
      m_rdy  = (m_pend.size() == 0) || m_load;
      m_pwm  = r_e && (m_pos < m_duty);
      m_fs   = r_e && (m_pos == 0);
      @(negedge clk);
      chk("rnd_ready", rdy, m_rdy);
      chk("rnd_pwm", pwm, m_pwm);
      chk("rnd_frame_start", fs, m_fs);
      chk("rnd_underrun", und, m_und);
      chk("rnd_underrun_cnt", ucnt, m_ucnt);
      if (r_r) begin
        model_reset();
      end else begin
        m_xfer = r_v && m_rdy;
        m_und  = m_load && (m_pend.size() == 0);
        if (m_load) begin
          if (m_pend.size() > 0) m_duty = m_pend.pop_front();
          else if (m_ucnt < 255) m_ucnt++;
        end
        if (m_xfer) m_pend.push_back((r_s > P) ? P : r_s);
        m_pos = r_e ? (m_pos + 1) % P : P - 1;
      end
      step();
    end
    rst = 1'b0; en = 1'b0; sv = 1'b0;

    // Default-period sweep fed from the sine table in order.
    rst2 = 1'b0;
    sv2 = 1'b1; smp2 = DW'(lut[0]);
    step();
    idx = 1;
    smp2 = DW'(lut[idx]);
    en2 = 1'b1;
    hi2_q.delete();
    hi2_on = 0;
    und2_seen = 0;
    for (int k = 0; k < (N2 + 3) * P2 && hi2_q.size() < N2; k++) begin
      @(negedge clk);
      m_xfer = sv2 && rdy2;
      step();
      if (m_xfer) begin
        idx++;
        smp2 = DW'(lut[idx % 64]);
      end
    end
    if (hi2_q.size() < N2) timeout("sine_frames");
    for (int k = 0; k < N2 && k < hi2_q.size(); k++)
      chk($sformatf("sine_frame%0d_hi", k), hi2_q[k], lut[k]);
    chk("sine_underrun_pulses", und2_seen, 0);
    chk("sine_underrun_cnt", ucnt2, 0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

endmodule
